int_controller: RTL and testbench
=================================

Name: int_controller

Overview:
- Multi-source interrupt controller for the jacaranda-8 core.
- Latches edge-triggered requests from peripherals, masks them and picks one by fixed priority.
- Drives the core's int_req / int_en / int_vec inputs and holds off further requests until the core executes ret.
- Configured by software through a small memory-mapped register window on the data-memory write path.

Parameters:
N_SRC, 4, number of interrupt sources (1..8)
BASE_ADDR, 8'hF0, data-memory address of register 0 (window is BASE_ADDR..BASE_ADDR+4)
VEC_STRIDE, 4, byte spacing between consecutive source vectors

Ports:
clock  input  1  system clock (same clock the core runs on)
reset  input  1  asynchronous, active-low reset
irq  input  N_SRC  peripheral request lines, synchronous to clock; rising edge = request
ret  input  1  high for the one cycle the core executes ret
addr  input  8  data-memory address from core (rs_data)
w_data  input  8  write data from core (rd_data)
w_en  input  1  data-memory write enable from core (mem_w_en)
r_data  output  8  register read data, combinational; 0 when addr is outside the window
int_req  output  1  interrupt request to core
int_en  output  8  interrupt enable to core ({7'b0, CTRL[0]})
int_vec  output  8  vector address to core

Behaviour:
- Reset (reset=0, asynchronous): CTRL, MASK, PEND, VBASE, irq_prev, idx and state all 0. Outputs int_req=0, int_vec=0, int_en=0.
- Registers (offset from BASE_ADDR):
  - 0 CTRL: bit0 global enable; bits 7:1 read 0.
  - 1 MASK: bit i=1 enables source i.
  - 2 PEND: read = pending bits; write-1-to-clear.
  - 3 VBASE: vector base.
  - 4 STATUS (read-only): bit7 = in_service, bits 2:0 = idx of last taken source.
  - Bits at N_SRC and above read 0 and are ignored on write.
- Writes commit on the rising clock edge when w_en=1 and addr is in the window.
- Edge detect: PEND[i] sets when irq[i]=1 and irq_prev[i]=0.
  - Set beats any clear in the same cycle, whether W1C or auto-clear.
- Candidate set = PEND & MASK. Lowest index wins.
- FSM states: IDLE, REQ, SERVICE, GUARD.
  - IDLE: if CTRL[0]=1 and the candidate set is non-empty, latch idx = winner, clear PEND[idx], and go to REQ.
  - REQ: int_req=1 for exactly one cycle. int_vec = VBASE + idx*VEC_STRIDE (8-bit wraparound), held stable from entry to REQ until the next REQ. Next state is SERVICE.
  - SERVICE: int_req=0; STATUS[7]=1. Pending bits keep accumulating. There is no nesting. On ret=1 go to GUARD.
  - GUARD: one cycle with int_req=0, so the instruction at the return address always executes and the core's saved return address is never overwritten by a request coincident with ret. Next state is IDLE.
- ret in IDLE or REQ is ignored.
- Clearing CTRL[0] while in REQ or SERVICE does not abort. The FSM still waits for ret; no new request is raised until CTRL[0]=1 again.
- A masked pending bit stays pending and is taken once it is unmasked.
- Latency: irq rising edge at cycle t → PEND set at edge t+1 → REQ at edge t+2 (int_req high during cycle t+2), assuming IDLE and enabled.
- int_en[0] mirrors CTRL[0] combinationally from the register. The core only acts when int_req and int_en[0] are both 1.

Test Plan:
1. Setup writes: CTRL=1, MASK=4'b0011, VBASE=8'h80. Pulse irq[1] → int_req high exactly 1 cycle, int_vec=8'h84. PEND reads 0 afterwards. STATUS=8'h81 until ret.
2. irq[0] and irq[1] rise in the same cycle → vector 8'h80 first. After ret, GUARD, then a second REQ with int_vec=8'h84 no earlier than 2 cycles after ret.
3. Source 2 masked (MASK=4'b0011): pulse irq[2] → no int_req, PEND=4'b0100. Then write MASK=4'b0111 → REQ with int_vec=8'h88.
4. irq[0] rises during SERVICE → no int_req until ret. A ret-cycle request produces int_req no sooner than the cycle after GUARD.
5. Write PEND=4'b0001 in the same cycle irq[0] rises → PEND[0] ends at 1 (set wins). With VBASE=8'hFE and idx=1 → int_vec=8'h02 (wrap).
6. Assert reset low mid-SERVICE (asynchronous, between edges) → int_req=0, int_vec=0, all registers 0 immediately. After release, no REQ until CTRL is rewritten.

Source files
------------

// File: rtl/int_controller_if.sv
// int_controller_if: core-side request/vector lines and data-memory register window of the interrupt controller
interface int_controller_if #(parameter int N_SRC = 4);
  logic [N_SRC-1:0] irq;
  logic             ret;
  logic [7:0]       addr;
  logic [7:0]       w_data;
  logic             w_en;
  logic [7:0]       r_data;
  logic             int_req;
  logic [7:0]       int_en;
  logic [7:0]       int_vec;
  modport master (output irq, ret, addr, w_data, w_en, input r_data, int_req, int_en, int_vec);
  modport slave (input irq, ret, addr, w_data, w_en, output r_data, int_req, int_en, int_vec);
endinterface

// File: rtl/int_controller.sv
// int_controller: edge-latched, masked, fixed-priority interrupt controller for the jacaranda-8 core
module int_controller #(
  parameter int         N_SRC      = 4,
  parameter logic [7:0] BASE_ADDR  = 8'hF0,
  parameter int         VEC_STRIDE = 4
) (
  input logic clock,
  input logic reset,
  int_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE, GUARD} state_t;
  state_t           state_q, state_d;
  logic             ctrl_q, ctrl_d;
  logic [N_SRC-1:0] mask_q, mask_d, pend_q, pend_d, prev_q;
  logic [7:0]       vbase_q, vbase_d, vec_q, vec_d;
  logic [2:0]       idx_q, idx_d, win;
  logic [N_SRC-1:0] cand, rise, sel, w1c;
  logic [7:0]       off;
  logic             wr, take, int_req, in_service;
  assign off  = bus.addr - BASE_ADDR;
  assign wr   = bus.w_en && off <= 8'd4;
  assign cand = pend_q & mask_q;
  assign rise = bus.irq & ~prev_q;
  assign take = state_q == IDLE && ctrl_q && |cand;
  assign w1c  = wr && off == 8'd2 ? bus.w_data[N_SRC-1:0] : '0;
  always_comb begin
    win = '0;
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (cand[i]) begin
        win    = 3'(i);
        sel    = '0;
        sel[i] = 1'b1;
      end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = take ? REQ : IDLE;
      REQ:     state_d = SERVICE;
      SERVICE: state_d = bus.ret ? GUARD : SERVICE;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    int_req    = state_q == REQ;
    in_service = state_q == SERVICE;
  end
  // A new edge in the same cycle always survives both W1C and the take-clear.
  always_comb begin
    ctrl_d  = wr && off == 8'd0 ? bus.w_data[0] : ctrl_q;
    mask_d  = wr && off == 8'd1 ? bus.w_data[N_SRC-1:0] : mask_q;
    vbase_d = wr && off == 8'd3 ? bus.w_data : vbase_q;
    pend_d  = (pend_q & ~w1c & ~(take ? sel : '0)) | rise;
    idx_d   = take ? win : idx_q;
    vec_d   = take ? vbase_q + 8'(32'(win) * VEC_STRIDE) : vec_q;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ctrl_q  <= 1'b0;
      mask_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      vbase_q <= '0;
      vec_q   <= '0;
      idx_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      prev_q  <= bus.irq;
      vbase_q <= vbase_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
    end
  always_comb
    bus.r_data = off == 8'd0 ? {7'b0, ctrl_q} :
                 off == 8'd1 ? 8'(mask_q) :
                 off == 8'd2 ? 8'(pend_q) :
                 off == 8'd3 ? vbase_q :
                 off == 8'd4 ? {in_service, 4'b0, idx_q} : 8'h00;
  assign bus.int_req = int_req;
  assign bus.int_en  = {7'b0, ctrl_q};
  assign bus.int_vec = vec_q;
endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: directed stimulus, behavioural model and per-cycle output comparison for int_controller
module tb_int_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  int_controller_if #(.N_SRC(4)) bus ();
  int_controller #(.N_SRC(4), .BASE_ADDR(8'hF0), .VEC_STRIDE(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  bit       m_ctrl, m_req, m_srv, m_guard;
  bit [3:0] m_mask, m_pend, m_prev;
  bit [7:0] m_vbase, m_vec;
  int       m_idx;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] m_rdata(input logic [7:0] a);
    case (a)
      8'hF0:   return {7'b0, m_ctrl};
      8'hF1:   return {4'b0, m_mask};
      8'hF2:   return {4'b0, m_pend};
      8'hF3:   return m_vbase;
      8'hF4:   return {m_srv, 4'b0, 3'(m_idx)};
      default: return 8'h00;
    endcase
  endfunction
  task automatic m_reset;
    m_ctrl = 0; m_req = 0; m_srv = 0; m_guard = 0;
    m_mask = 0; m_pend = 0; m_prev = 0; m_vbase = 0; m_vec = 0; m_idx = 0;
  endtask
  // Advance one clock: model next state from the inputs as they stand before the edge.
  task automatic step;
    bit [3:0] rise, clr, w1c, irq_now, n_mask;
    bit       n_req, n_srv, n_guard, n_ctrl;
    bit [7:0] n_vbase, n_vec;
    int       n_idx;
    if (!reset) begin
      @(posedge clock);
      m_reset;
      #1;
      return;
    end
    irq_now = bus.irq;
    rise = irq_now & ~m_prev;
    clr = 0; w1c = 0;
    n_req = 0; n_srv = m_srv || m_req; n_guard = 0;
    n_idx = m_idx; n_vec = m_vec;
    n_ctrl = m_ctrl; n_mask = m_mask; n_vbase = m_vbase;
    if (m_srv && bus.ret) begin
      n_srv = 0;
      n_guard = 1;
    end
    if (!m_req && !m_srv && !m_guard && m_ctrl && (m_pend & m_mask) != 0) begin
      for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) n_idx = i;
      n_req = 1;
      clr[n_idx] = 1;
      n_vec = 8'((int'(m_vbase) + 4 * n_idx) % 256);
    end
    if (bus.w_en)
      case (bus.addr)
        8'hF0: n_ctrl = bus.w_data[0];
        8'hF1: n_mask = bus.w_data[3:0];
        8'hF2: w1c = bus.w_data[3:0];
        8'hF3: n_vbase = bus.w_data;
        default: ;
      endcase
    @(posedge clock);
    m_pend = (m_pend & ~clr & ~w1c) | rise;
    m_prev = irq_now;
    m_req = n_req; m_srv = n_srv; m_guard = n_guard;
    m_idx = n_idx; m_vec = n_vec;
    m_ctrl = n_ctrl; m_mask = n_mask; m_vbase = n_vbase;
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.addr = a; bus.w_data = d; bus.w_en = 1'b1;
    step;
    bus.w_en = 1'b0;
  endtask
  task automatic rd(input string nm, input logic [7:0] a, input logic [7:0] exp);
    bus.addr = a;
    #1;
    chk(nm, bus.r_data, exp);
  endtask
  task automatic ret_pulse;
    bus.ret = 1'b1;
    step;
    bus.ret = 1'b0;
  endtask
  always @(negedge clock) begin
    chk("int_req", {7'b0, bus.int_req}, {7'b0, m_req});
    chk("int_vec", bus.int_vec, m_vec);
    chk("int_en", bus.int_en, {7'b0, m_ctrl});
    chk("r_data", bus.r_data, m_rdata(bus.addr));
  end
  initial begin
    bus.irq = 0; bus.ret = 0; bus.addr = 0; bus.w_data = 0; bus.w_en = 0;
    m_reset;
    step; step;
    chk("rst_req", {7'b0, bus.int_req}, 8'h00);
    chk("rst_vec", bus.int_vec, 8'h00);
    chk("rst_en", bus.int_en, 8'h00);
    reset = 1'b1;
    wr(8'hF0, 8'h01); wr(8'hF1, 8'h03); wr(8'hF3, 8'h80);
    chk("t1_en", bus.int_en, 8'h01);
    bus.irq = 4'b0010; step; bus.irq = 0;
    chk("t1_pend_cycle", {7'b0, bus.int_req}, 8'h00);
    step;
    chk("t1_req", {7'b0, bus.int_req}, 8'h01);
    chk("t1_vec", bus.int_vec, 8'h84);
    step;
    chk("t1_one_cycle", {7'b0, bus.int_req}, 8'h00);
    rd("t1_pend", 8'hF2, 8'h00);
    rd("t1_status", 8'hF4, 8'h81);
    step; step;
    rd("t1_status_hold", 8'hF4, 8'h81);
    ret_pulse;
    rd("t1_status_guard", 8'hF4, 8'h01);
    step;
    bus.irq = 4'b0011; step; bus.irq = 0; step;
    chk("t2_req0", {7'b0, bus.int_req}, 8'h01);
    chk("t2_vec0", bus.int_vec, 8'h80);
    step; ret_pulse;
    chk("t2_guard", {7'b0, bus.int_req}, 8'h00);
    step;
    chk("t2_idle", {7'b0, bus.int_req}, 8'h00);
    step;
    chk("t2_req1", {7'b0, bus.int_req}, 8'h01);
    chk("t2_vec1", bus.int_vec, 8'h84);
    step; ret_pulse; step;
    bus.irq = 4'b0100; step; bus.irq = 0; step; step;
    chk("t3_masked", {7'b0, bus.int_req}, 8'h00);
    rd("t3_pend", 8'hF2, 8'h04);
    wr(8'hF1, 8'h07);
    chk("t3_unmask_edge", {7'b0, bus.int_req}, 8'h00);
    step;
    chk("t3_req", {7'b0, bus.int_req}, 8'h01);
    chk("t3_vec", bus.int_vec, 8'h88);
    step; ret_pulse; step;
    bus.irq = 4'b0010; step; bus.irq = 0; step; step;
    bus.irq = 4'b0001; step; bus.irq = 0; step; step;
    chk("t4_no_nest", {7'b0, bus.int_req}, 8'h00);
    rd("t4_pend", 8'hF2, 8'h01);
    bus.irq = 4'b0010; ret_pulse; bus.irq = 0;
    chk("t4_guard", {7'b0, bus.int_req}, 8'h00);
    step;
    chk("t4_idle", {7'b0, bus.int_req}, 8'h00);
    step;
    chk("t4_req0", {7'b0, bus.int_req}, 8'h01);
    chk("t4_vec0", bus.int_vec, 8'h80);
    step; ret_pulse; step; step;
    chk("t4_req1", {7'b0, bus.int_req}, 8'h01);
    chk("t4_vec1", bus.int_vec, 8'h84);
    step; ret_pulse; step;
    wr(8'hF0, 8'h00);
    bus.irq = 4'b0001; bus.addr = 8'hF2; bus.w_data = 8'h01; bus.w_en = 1'b1;
    step;
    bus.w_en = 1'b0; bus.irq = 0;
    rd("t5_set_wins", 8'hF2, 8'h01);
    wr(8'hF2, 8'h01);
    rd("t5_w1c", 8'hF2, 8'h00);
    wr(8'hF3, 8'hFE); wr(8'hF1, 8'h02); wr(8'hF0, 8'h01);
    bus.irq = 4'b0010; step; bus.irq = 0; step;
    chk("t5_req", {7'b0, bus.int_req}, 8'h01);
    chk("t5_wrap", bus.int_vec, 8'h02);
    step;
    rd("t5_status", 8'hF4, 8'h81);
    #1 reset = 1'b0;
    #1 m_reset;
    chk("t6_req", {7'b0, bus.int_req}, 8'h00);
    chk("t6_vec", bus.int_vec, 8'h00);
    chk("t6_en", bus.int_en, 8'h00);
    rd("t6_status", 8'hF4, 8'h00);
    step; step;
    reset = 1'b1;
    bus.irq = 4'b0001; step; bus.irq = 0; step; step; step;
    chk("t6_no_req", {7'b0, bus.int_req}, 8'h00);
    rd("t6_pend", 8'hF2, 8'h01);
    wr(8'hF0, 8'h01); step;
    chk("t6_masked", {7'b0, bus.int_req}, 8'h00);
    wr(8'hF1, 8'h01); step;
    chk("t6_req_after", {7'b0, bus.int_req}, 8'h01);
    step; ret_pulse; step; step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
